// File: rtl/seven_segment_capture.sv
// Seven-segment display snooper: watches a multiplexed segment/anode bus,
// waits for each digit pattern to settle, decodes it to a hex nibble and
// publishes a complete frame once every digit position has been captured.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT     | dwell = 0; input register just (re)loaded, nothing settled
// SETTLING | 0 < dwell < STABLE_CYCLES; pattern repeating, not yet trusted
// HELD     | dwell = STABLE_CYCLES; pattern captured once, waiting for change
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     an_in,
  output logic [4*NUM_DIGITS-1:0]   value_out,
  output logic [NUM_DIGITS-1:0]     err_out,
  output logic                      frame_valid
);

  localparam int             DW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [DW-1:0]  DWELL_MAX = DW'(STABLE_CYCLES);
  localparam logic [DW-1:0]  DWELL_PRE = DW'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } dwell_state_t;

  dwell_state_t state_q, state_d;
  logic [DW-1:0]            dwell_q, dwell_d;
  logic [NUM_DIGITS-1:0]    an_q;
  logic [6:0]               seg_q;
  logic                     an_onehot;
  logic                     match;
  logic                     capture;
  logic [4:0]               dec;

  logic [4*NUM_DIGITS-1:0]  shadow_val;
  logic [NUM_DIGITS-1:0]    shadow_err;
  logic [NUM_DIGITS-1:0]    seen_q, seen_d;
  logic                     publish;

  // Returns {err, nibble}; anything outside the hex font (blank included) is an error.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h0D:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Only a single active anode that repeats the registered pattern counts as dwell.
  always_comb begin
    an_onehot = (an_in != '0) && ((an_in & (an_in - AN_ONE)) == '0);
    match     = an_onehot && ({an_in, seg_in} == {an_q, seg_q});
  end

  // Dwell state register plus the input snapshot it compares against.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      dwell_q <= '0;
      an_q    <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      if (!match) begin
        an_q  <= an_in;
        seg_q <= seg_in;
      end
    end
  end

  // Next dwell state: any change or non-one-hot anode restarts, otherwise count up and saturate.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (!match) begin
      state_d = ST_WAIT;
      dwell_d = '0;
    end else if (dwell_q != DWELL_MAX) begin
      dwell_d = dwell_q + 1'b1;
      state_d = (dwell_q == DWELL_PRE) ? ST_HELD : ST_SETTLING;
    end else begin
      state_d = ST_HELD;
    end
  end

  // Capture strobe fires only on the edge that enters HELD, so one capture per dwell.
  always_comb begin
    capture = match && (state_q != ST_HELD) && (dwell_q == DWELL_PRE);
    dec     = decode_seg(seg_q);
  end

  // Seen mask: a publish empties it, but a capture on that same edge starts the next frame.
  always_comb begin
    publish = &seen_q;
    seen_d  = publish ? '0 : seen_q;
    if (capture) seen_d = seen_d | an_q;
  end

  // Shadow frame, seen mask and published outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_val  <= '0;
      shadow_err  <= '0;
      seen_q      <= '0;
      value_out   <= '0;
      err_out     <= '0;
      frame_valid <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      frame_valid <= publish;
      if (publish) begin
        value_out <= shadow_val;
        err_out   <= shadow_err;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && an_q[i]) begin
          shadow_val[4*i +: 4] <= dec[3:0];
          shadow_err[i]        <= dec[4];
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: stimulus queues expected frames,
// a negedge monitor checks each frame_valid pulse against the queue head.
module tb_seven_segment_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [6:0]      seg_in;
  logic [ND-1:0]   an_in;
  logic [4*ND-1:0] value_out;
  logic [ND-1:0]   err_out;
  logic            frame_valid;

  seven_segment_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value_out   (value_out),
    .err_out     (err_out),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  e;
    int          c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int last_apply = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every frame_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got value %h err %b at cycle %0d expected no frame",
                 value_out, err_out, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("frame_value", 32'(value_out), 32'(x.v));
        check("frame_err", 32'(err_out), 32'(x.e));
        check("frame_cycle", 32'(cyc), 32'(x.c));
      end
    end
  end

  task automatic digit(input logic [3:0] an, input logic [6:0] seg, input int n);
    @(negedge clk);
    an_in      = an;
    seg_in     = seg;
    last_apply = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  // Publish lands SC+1 edges after the first edge that sees the final digit.
  task automatic expect_frame(input logic [15:0] v, input logic [3:0] e);
    exp_t x;
    x.v = v;
    x.e = e;
    x.c = last_apply + SC + 2;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    an_in  = '0;
    seg_in = '0;
    repeat (2) @(negedge clk);
    check("reset_value", 32'(value_out), 32'h0);
    check("reset_err", 32'(err_out), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    an_in  = '0;
    seg_in = '0;
    do_reset();

    // Idle with no anode active: nothing captured or published.
    repeat (8) @(negedge clk);
    check("idle_value", 32'(value_out), 32'h0);
    check("idle_err", 32'(err_out), 32'h0);

    // Straight scan 1,2,3,4.
    digit(4'b0001, 7'h30, 6);
    digit(4'b0010, 7'h6D, 6);
    digit(4'b0100, 7'h79, 6);
    digit(4'b1000, 7'h33, 6);
    expect_frame(16'h4321, 4'b0000);
    repeat (2) @(negedge clk);

    // Digit 1 too short first time; frame completes only on its later long hold.
    digit(4'b0001, 7'h5B, 6);
    digit(4'b0010, 7'h5F, 3);
    digit(4'b0100, 7'h70, 6);
    digit(4'b1000, 7'h7E, 6);
    check("hold_value", 32'(value_out), 32'h4321);
    digit(4'b0010, 7'h5F, 6);
    expect_frame(16'h0765, 4'b0000);
    repeat (2) @(negedge clk);

    // Blank on digit 2 decodes to 0 with its error flag.
    digit(4'b0001, 7'h7F, 6);
    digit(4'b0010, 7'h7F, 6);
    digit(4'b0100, 7'h00, 6);
    digit(4'b1000, 7'h7F, 6);
    expect_frame(16'h8088, 4'b0100);
    repeat (2) @(negedge clk);

    // Out-of-order scan with letter glyphs.
    digit(4'b1000, 7'h77, 6);
    digit(4'b0010, 7'h1F, 6);
    digit(4'b0001, 7'h0D, 6);
    digit(4'b0100, 7'h3D, 6);
    expect_frame(16'hADBC, 4'b0000);
    repeat (2) @(negedge clk);

    // Multi-hot anodes in mid-scan are ignored entirely.
    digit(4'b0001, 7'h4F, 6);
    digit(4'b0010, 7'h47, 6);
    digit(4'b0011, 7'h00, 10);
    digit(4'b0100, 7'h7B, 6);
    digit(4'b1000, 7'h1F, 6);
    expect_frame(16'hB9FE, 4'b0000);
    repeat (2) @(negedge clk);

    // Partial frame then reset: only the post-reset scan may publish.
    digit(4'b0001, 7'h30, 6);
    digit(4'b0010, 7'h30, 6);
    check("partial_hold_value", 32'(value_out), 32'hB9FE);
    do_reset();
    digit(4'b0001, 7'h6D, 6);
    digit(4'b0010, 7'h79, 6);
    digit(4'b0100, 7'h5B, 6);
    digit(4'b1000, 7'h70, 6);
    expect_frame(16'h7532, 4'b0000);

    @(negedge clk);
    an_in = '0;
    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of multiplexed digit positions monitored (2..8).
REQ-002 Parameter: STABLE_CYCLES, default 4, consecutive clock edges a one-hot pattern must hold before capture (2..255).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: seg_in  input  7  segment bus, bit6=a ... bit0=g, 1=lit.
REQ-006 Port: an_in  input  NUM_DIGITS  digit enables, active-high; bit i selects digit i.
REQ-007 Port: value_out  output  4*NUM_DIGITS  decoded frame; digit i in bits [4i+3:4i].
REQ-008 Port: err_out  output  NUM_DIGITS  bit i set when digit i held an undecodable pattern in the published frame.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when value_out/err_out update.

Function
REQ-010 The decode table SHALL be: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 0D->C, 3D->D, 4F->E, 47->F; values are hex on seg_in.
REQ-011 Any other seg_in value, including 00 (blank), SHALL decode to nibble 0 with the digit's error flag set.
REQ-012 Input register {an_q, seg_q} and dwell counter (0..STABLE_CYCLES, saturating) SHALL update every edge.
REQ-013 Per edge: if {an_in, seg_in} equals {an_q, seg_q} and an_in is one-hot, dwell increments (saturating at STABLE_CYCLES); otherwise {an_q, seg_q} loads inputs and dwell clears to 0.
REQ-014 Dwell states: WAIT (dwell=0), SETTLING (0<dwell<STABLE_CYCLES), HELD (dwell=STABLE_CYCLES); HELD exits only through a mismatch or a non-one-hot input.
REQ-015 Capture SHALL occur on exactly the edge where dwell goes STABLE_CYCLES-1 -> STABLE_CYCLES.
REQ-016 Capture writes the decoded nibble and error flag into digit i's shadow and sets seen[i]; exactly one capture per dwell.
REQ-017 an_in all-zero or multi-hot SHALL never capture or flag an error; dwell stays 0.
REQ-018 A repeat capture of a digit already seen in the current frame SHALL overwrite its shadow; seen[i] remains set.
REQ-019 When seen is all-ones at an edge, that edge SHALL copy shadows to value_out/err_out, clear seen, and drive frame_valid high for the following cycle only.
REQ-020 Latency: inputs stable before edge 0 -> capture at edge STABLE_CYCLES -> publish and frame_valid at edge STABLE_CYCLES+1.
REQ-021 A capture on the publish edge SHALL set seen for the next frame; it SHALL NOT be lost.
REQ-022 value_out and err_out SHALL hold between publishes.
REQ-023 Digits may be scanned in any order; scan order SHALL not affect the result.

Reset
REQ-024 Reset SHALL clear value_out, err_out, frame_valid, shadows, seen, an_q, seg_q and dwell to 0.
REQ-025 Reset SHALL take priority over capture and publish on the same edge; a partially captured frame is discarded.

Verification
REQ-026 Assert reset 2 cycles -> value_out=0000, err_out=0000, frame_valid=0; outputs stay 0 while an_in=0.
REQ-027 Scan an_in 0001/0010/0100/1000 with seg_in 30/6D/79/33, 6 cycles each -> value_out=16'h4321, err_out=0000, single frame_valid pulse 5 edges after the last digit is applied.
REQ-028 Hold digit 1 for only 3 cycles (STABLE_CYCLES=4) within an otherwise complete scan -> no frame_valid; it appears after digit 1 holds for 4 or more edges.
REQ-029 Full scan with seg_in=00 on digit 2 and 7F elsewhere -> value_out=16'h8088, err_out=0100.
REQ-030 Drive an_in=0011 for 10 cycles between valid digits -> no capture, no error; frame result is unchanged.
REQ-031 Capture digits 0 and 1, assert reset, then scan all 4 -> exactly one frame_valid, after digit 3, with only post-reset values.
